// File: rtl/beta_dmem_resp.sv
// beta_dmem_resp: word-organised data-memory responder for the beta LSU read/write req/ready/valid ports.
// Define BETA_DMEM_ERR_EN to add err_o and out-of-range address suppression; otherwise addresses wrap.
module beta_dmem_resp #(
    parameter int DataWidth    = 32,
    parameter int AddressWidth = 32,
    parameter int Depth        = 1024,
    parameter int Latency      = 1
) (
    input  logic                    clk_i,
    input  logic                    rstn_i,
    input  logic                    rdata_req_i,
    input  logic [AddressWidth-1:0] rdata_addr_i,
    input  logic [3:0]              rdata_strb_i,
    output logic                    rdata_ready_o,
    output logic                    rdata_valid_o,
    output logic [DataWidth-1:0]    rdata_data_o,
    input  logic                    wdata_req_i,
    input  logic [AddressWidth-1:0] wdata_addr_i,
    input  logic [3:0]              wdata_strb_i,
    input  logic [DataWidth-1:0]    wdata_data_i,
    output logic                    wdata_ready_o,
    output logic                    wdata_valid_o
`ifdef BETA_DMEM_ERR_EN
    ,
    output logic                    err_o
`endif
);

    localparam int IW = $clog2(Depth);
    localparam int CW = (Latency > 2) ? $clog2(Latency) : 1;
    localparam logic [CW-1:0] CNT_LOAD = (Latency > 2) ? CW'(Latency - 2) : {CW{1'b0}};

    typedef enum logic [1:0] {IDLE, ACK, WAIT, RESP} state_t;

    function automatic logic [DataWidth-1:0] expand_strb(input logic [3:0] strb);
        logic [DataWidth-1:0] mask;
        mask = {DataWidth{1'b0}};
        for (int i = 0; i < 4; i++) begin
            mask[8*i +: 8] = {8{strb[i]}};
        end
        return mask;
    endfunction

    state_t                  state_r, state_n;
    logic                    sel_wr_r, sel_wr_n;
    logic [CW-1:0]           cnt_r, cnt_n;
    logic                    accept_s;
    logic [AddressWidth-1:0] addr_r;
    logic [3:0]              strb_r;
    logic [DataWidth-1:0]    wdata_r;
    logic                    rready_r, wready_r, rvalid_r, wvalid_r;
    logic [DataWidth-1:0]    rdata_r;
    logic [DataWidth-1:0]    mem_r [Depth];

    logic [1:0]              off_s;
    logic [IW-1:0]           idx_s;
    logic [6:0]              strb_sh_s;
    logic [3:0]              wmask_s;
    logic [DataWidth-1:0]    wdata_sh_s;
    logic [DataWidth-1:0]    read_val_s;
    logic                    resp_n_s;
    logic                    addr_err_s;
    logic                    commit_s;
    logic                    rd_fire_s;

    // Next-state logic; writes take priority over a simultaneous read, which stays pending.
    always_comb begin
        state_n  = state_r;
        sel_wr_n = sel_wr_r;
        cnt_n    = cnt_r;
        accept_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (wdata_req_i) begin
                    accept_s = 1'b1;
                    sel_wr_n = 1'b1;
                    state_n  = ACK;
                end else if (rdata_req_i) begin
                    accept_s = 1'b1;
                    sel_wr_n = 1'b0;
                    state_n  = ACK;
                end else begin
                    state_n  = IDLE;
                end
            end
            ACK: begin
                if (Latency == 1) begin
                    state_n = RESP;
                end else begin
                    cnt_n   = CNT_LOAD;
                    state_n = WAIT;
                end
            end
            WAIT: begin
                if (cnt_r == {CW{1'b0}}) begin
                    state_n = RESP;
                end else begin
                    cnt_n   = cnt_r - {{(CW-1){1'b0}}, 1'b1};
                    state_n = WAIT;
                end
            end
            RESP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    assign off_s      = addr_r[1:0];
    assign idx_s      = addr_r[IW+1:2];
    assign strb_sh_s  = {3'b000, strb_r} << off_s;
    assign wmask_s    = strb_sh_s[3:0];
    assign wdata_sh_s = wdata_r << {off_s, 3'b000};
    assign read_val_s = (mem_r[idx_s] >> {off_s, 3'b000}) & expand_strb(strb_r);
    assign resp_n_s   = (state_n == RESP);
    assign commit_s   = resp_n_s && sel_wr_r && !addr_err_s;
    assign rd_fire_s  = resp_n_s && !sel_wr_r;

`ifdef BETA_DMEM_ERR_EN
    logic err_r;
    assign addr_err_s = |addr_r[AddressWidth-1:IW+2];

    // Error flag accompanies the valid pulse of an out-of-range access.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            err_r <= 1'b0;
        end else begin
            err_r <= resp_n_s && addr_err_s;
        end
    end
    assign err_o = err_r;
`else
    logic unused_addr_s;
    assign addr_err_s    = 1'b0;
    assign unused_addr_s = ^addr_r[AddressWidth-1:IW+2];
`endif

    // State, request capture and registered handshake/data outputs.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_r  <= IDLE;
            sel_wr_r <= 1'b0;
            cnt_r    <= {CW{1'b0}};
            addr_r   <= {AddressWidth{1'b0}};
            strb_r   <= 4'b0000;
            wdata_r  <= {DataWidth{1'b0}};
            rready_r <= 1'b0;
            wready_r <= 1'b0;
            rvalid_r <= 1'b0;
            wvalid_r <= 1'b0;
            rdata_r  <= {DataWidth{1'b0}};
        end else begin
            state_r  <= state_n;
            sel_wr_r <= sel_wr_n;
            cnt_r    <= cnt_n;
            if (accept_s) begin
                addr_r  <= sel_wr_n ? wdata_addr_i : rdata_addr_i;
                strb_r  <= sel_wr_n ? wdata_strb_i : rdata_strb_i;
                wdata_r <= wdata_data_i;
            end
            rready_r <= (state_n == ACK) && !sel_wr_n;
            wready_r <= (state_n == ACK) && sel_wr_n;
            rvalid_r <= rd_fire_s;
            wvalid_r <= resp_n_s && sel_wr_r;
            if (rd_fire_s) begin
                rdata_r <= addr_err_s ? {DataWidth{1'b0}} : read_val_s;
            end
        end
    end

    // RAM byte-lane write; contents survive reset, and reset blocks a pending commit.
    always_ff @(posedge clk_i) begin
        if (commit_s && rstn_i) begin
            for (int i = 0; i < 4; i++) begin
                if (wmask_s[i]) begin
                    mem_r[idx_s][8*i +: 8] <= wdata_sh_s[8*i +: 8];
                end
            end
        end
    end

    assign rdata_ready_o = rready_r;
    assign rdata_valid_o = rvalid_r;
    assign rdata_data_o  = rdata_r;
    assign wdata_ready_o = wready_r;
    assign wdata_valid_o = wvalid_r;

endmodule

// File: tb/tb_beta_dmem_resp.sv
// Self-checking bench for beta_dmem_resp: a Latency=1 and a Latency=4 instance against a byte-level memory model.
// Honours BETA_DMEM_ERR_EN the same way as the design.
module tb_beta_dmem_resp;

`ifdef BETA_DMEM_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    logic        r1_req, r1_rdy, r1_vld, w1_req, w1_rdy, w1_vld, e1;
    logic [31:0] r1_addr, r1_data, w1_addr, w1_data;
    logic [3:0]  r1_strb, w1_strb;
    logic        r4_req, r4_rdy, r4_vld, w4_req, w4_rdy, w4_vld, e4;
    logic [31:0] r4_addr, r4_data, w4_addr, w4_data;
    logic [3:0]  r4_strb, w4_strb;

    beta_dmem_resp #(.Latency(1)) dut1 (
        .clk_i(clk), .rstn_i(rstn),
        .rdata_req_i(r1_req), .rdata_addr_i(r1_addr), .rdata_strb_i(r1_strb),
        .rdata_ready_o(r1_rdy), .rdata_valid_o(r1_vld), .rdata_data_o(r1_data),
        .wdata_req_i(w1_req), .wdata_addr_i(w1_addr), .wdata_strb_i(w1_strb), .wdata_data_i(w1_data),
        .wdata_ready_o(w1_rdy), .wdata_valid_o(w1_vld)
`ifdef BETA_DMEM_ERR_EN
        , .err_o(e1)
`endif
    );

    beta_dmem_resp #(.Latency(4)) dut4 (
        .clk_i(clk), .rstn_i(rstn),
        .rdata_req_i(r4_req), .rdata_addr_i(r4_addr), .rdata_strb_i(r4_strb),
        .rdata_ready_o(r4_rdy), .rdata_valid_o(r4_vld), .rdata_data_o(r4_data),
        .wdata_req_i(w4_req), .wdata_addr_i(w4_addr), .wdata_strb_i(w4_strb), .wdata_data_i(w4_data),
        .wdata_ready_o(w4_rdy), .wdata_valid_o(w4_vld)
`ifdef BETA_DMEM_ERR_EN
        , .err_o(e4)
`endif
    );

`ifndef BETA_DMEM_ERR_EN
    assign e1 = 1'b0;
    assign e4 = 1'b0;
`endif

    int total = 0;
    int bad = 0;
    logic [31:0] mdl [2][1024];

    function automatic bit oob(input logic [31:0] a);
        return ERR_EN && (a[31:2] >= 30'd1024);
    endfunction

    task automatic model_write(input int d, input logic [31:0] a, input logic [3:0] s, input logic [31:0] wd);
        int w = int'(a[11:2]);
        int off = int'(a[1:0]);
        if (!oob(a)) begin
            for (int k = 0; k < 4; k++) begin
                if (s[k] && (k + off) < 4) mdl[d][w][8*(k+off) +: 8] = wd[8*k +: 8];
            end
        end
    endtask

    function automatic logic [31:0] model_read(input int d, input logic [31:0] a, input logic [3:0] s);
        logic [31:0] r = 32'h0;
        int w = int'(a[11:2]);
        int off = int'(a[1:0]);
        if (oob(a)) return 32'h0;
        for (int k = 0; k < 4; k++) begin
            if (s[k] && (k + off) < 4) r[8*k +: 8] = mdl[d][w][8*(k+off) +: 8];
        end
        return r;
    endfunction

    task automatic set_req(input int d, input bit wr, input logic v, input logic [31:0] a,
                           input logic [3:0] s, input logic [31:0] wd);
        if (d == 1) begin
            if (wr) begin w4_req = v; w4_addr = a; w4_strb = s; w4_data = wd; end
            else begin r4_req = v; r4_addr = a; r4_strb = s; end
        end else begin
            if (wr) begin w1_req = v; w1_addr = a; w1_strb = s; w1_data = wd; end
            else begin r1_req = v; r1_addr = a; r1_strb = s; end
        end
    endtask

    task automatic peek(input int d, input bit wr, output logic rdy, output logic vld,
                        output logic [31:0] dt, output logic er);
        if (d == 1) begin
            rdy = wr ? w4_rdy : r4_rdy; vld = wr ? w4_vld : r4_vld; dt = r4_data; er = e4;
        end else begin
            rdy = wr ? w1_rdy : r1_rdy; vld = wr ? w1_vld : r1_vld; dt = r1_data; er = e1;
        end
    endtask

    // Drives one request and records handshake timing (negedges after the request was raised).
    task automatic txn(input int d, input bit wr, input logic [31:0] a, input logic [3:0] s,
                       input logic [31:0] wd, output int rdy_at, output int vld_at,
                       output int rdy_n, output int tail, output logic [31:0] rd, output logic er);
        logic rdy, vld, e;
        logic [31:0] dt;
        rdy_at = -1; vld_at = -1; rdy_n = 0; tail = 0; rd = 32'h0; er = 1'b0;
        set_req(d, wr, 1'b1, a, s, wd);
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            peek(d, wr, rdy, vld, dt, e);
            if (rdy) begin
                rdy_n++;
                if (rdy_at < 0) rdy_at = k;
                set_req(d, wr, 1'b0, a, s, wd);
            end
            if (vld) begin vld_at = k; rd = dt; er = e; break; end
        end
        set_req(d, wr, 1'b0, a, s, wd);
        @(negedge clk);
        peek(d, wr, rdy, vld, dt, e);
        tail = int'(rdy) + int'(vld);
    endtask

    task automatic test_reset();
        int n = 0;
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({r1_rdy, r1_vld, w1_rdy, w1_vld, e1, r1_data, r4_rdy, r4_vld, w4_rdy, w4_vld, e4, r4_data} !== 74'h0) begin
            bad++;
            $display("FAIL reset_outputs got=%h %h required all zero", r1_data, r4_data);
        end
        rstn = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (r1_rdy || r1_vld || w1_rdy || w1_vld || r4_rdy || r4_vld || w4_rdy || w4_vld) n++;
        end
        total++;
        if (n !== 0) begin bad++; $display("FAIL idle_quiet got=%0d handshake cycles required=0", n); end
    endtask

    task automatic test_word();
        int ra, va, rn, tl;
        logic [31:0] rd;
        logic er;
        txn(0, 1'b1, 32'h100, 4'hF, 32'hDEADBEEF, ra, va, rn, tl, rd, er);
        model_write(0, 32'h100, 4'hF, 32'hDEADBEEF);
        total++;
        if (ra !== 1 || va !== 2) begin bad++; $display("FAIL word_wr_timing got=%0d/%0d required=1/2", ra, va); end
        txn(0, 1'b0, 32'h100, 4'hF, 32'h0, ra, va, rn, tl, rd, er);
        total++;
        if (rd !== 32'hDEADBEEF) begin bad++; $display("FAIL word_rd got=%h required=deadbeef", rd); end
        total++;
        if (ra !== 1 || va !== 2 || rn !== 1 || tl !== 0) begin
            bad++; $display("FAIL word_rd_timing got=%0d/%0d/%0d/%0d required=1/2/1/0", ra, va, rn, tl);
        end
    endtask

    task automatic test_subword();
        int ra, va, rn, tl;
        logic [31:0] rd;
        logic er;
        logic [31:0] exp_v [3] = '{32'hAA223344, 32'h0000AA22, 32'h00000033};
        logic [31:0] adr_v [3] = '{32'h200, 32'h202, 32'h201};
        logic [3:0]  stb_v [3] = '{4'hF, 4'h3, 4'h1};
        txn(0, 1'b1, 32'h200, 4'hF, 32'h11223344, ra, va, rn, tl, rd, er);
        model_write(0, 32'h200, 4'hF, 32'h11223344);
        txn(0, 1'b1, 32'h203, 4'h1, 32'h000000AA, ra, va, rn, tl, rd, er);
        model_write(0, 32'h203, 4'h1, 32'h000000AA);
        for (int i = 0; i < 3; i++) begin
            txn(0, 1'b0, adr_v[i], stb_v[i], 32'h0, ra, va, rn, tl, rd, er);
            total++;
            if (rd !== exp_v[i]) begin bad++; $display("FAIL subword_rd%0d got=%h required=%h", i, rd, exp_v[i]); end
        end
        txn(0, 1'b1, 32'h200, 4'h0, 32'hFFFFFFFF, ra, va, rn, tl, rd, er);
        total++;
        if (va !== 2) begin bad++; $display("FAIL strb0_wr_valid got=%0d required=2", va); end
        txn(0, 1'b0, 32'h200, 4'hF, 32'h0, ra, va, rn, tl, rd, er);
        total++;
        if (rd !== 32'hAA223344) begin bad++; $display("FAIL strb0_unchanged got=%h required=aa223344", rd); end
        txn(0, 1'b0, 32'h200, 4'h0, 32'h0, ra, va, rn, tl, rd, er);
        total++;
        if (rd !== 32'h0) begin bad++; $display("FAIL strb0_rd got=%h required=0", rd); end
    endtask

    task automatic test_collision();
        int ra, va, rn, tl;
        int wr_r = -1, wr_v = -1, rd_r = -1, rd_v = -1;
        logic [31:0] rd;
        logic er;
        txn(0, 1'b1, 32'h300, 4'hF, 32'h55555555, ra, va, rn, tl, rd, er);
        set_req(0, 1'b1, 1'b1, 32'h300, 4'hF, 32'h12345678);
        set_req(0, 1'b0, 1'b1, 32'h300, 4'hF, 32'h0);
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (w1_rdy && wr_r < 0) begin wr_r = k; w1_req = 1'b0; end
            if (w1_vld && wr_v < 0) wr_v = k;
            if (r1_rdy && rd_r < 0) begin rd_r = k; r1_req = 1'b0; end
            if (r1_vld && rd_v < 0) begin rd_v = k; rd = r1_data; break; end
        end
        w1_req = 1'b0; r1_req = 1'b0;
        model_write(0, 32'h300, 4'hF, 32'h12345678);
        total++;
        if (wr_r !== 1 || wr_v !== 2) begin bad++; $display("FAIL coll_wr_first got=%0d/%0d required=1/2", wr_r, wr_v); end
        total++;
        if (rd_r !== 4 || rd_v !== 5) begin bad++; $display("FAIL coll_rd_next got=%0d/%0d required=4/5", rd_r, rd_v); end
        total++;
        if (rd !== 32'h12345678) begin bad++; $display("FAIL coll_rd_data got=%h required=12345678", rd); end
        @(negedge clk);
    endtask

    task automatic test_latency4();
        int ra, va, rn, tl, n = 0;
        logic [31:0] rd;
        logic er;
        txn(1, 1'b1, 32'h40, 4'hF, 32'hCAFEF00D, ra, va, rn, tl, rd, er);
        model_write(1, 32'h40, 4'hF, 32'hCAFEF00D);
        total++;
        if (ra !== 1 || rn !== 1 || va - ra !== 4 || tl !== 0) begin
            bad++; $display("FAIL lat4_wr_timing got=%0d/%0d/%0d/%0d required=1/1/5/0", ra, rn, va, tl);
        end
        txn(1, 1'b0, 32'h40, 4'hF, 32'h0, ra, va, rn, tl, rd, er);
        total++;
        if (rd !== 32'hCAFEF00D || va !== 5) begin bad++; $display("FAIL lat4_rd got=%h@%0d required=cafef00d@5", rd, va); end
        set_req(1, 1'b1, 1'b1, 32'h40, 4'hF, 32'h0BADBEEF);
        @(negedge clk);
        w4_req = 1'b0;
        @(negedge clk);
        rstn = 1'b0;
        #1;
        total++;
        if ({w4_rdy, w4_vld, r4_rdy, r4_vld, r4_data} !== 36'h0) begin
            bad++; $display("FAIL lat4_rst_outputs got=%b%b data=%h required zeros", w4_rdy, w4_vld, r4_data);
        end
        @(negedge clk);
        rstn = 1'b1;
        repeat (8) begin @(negedge clk); if (w4_vld || w4_rdy) n++; end
        total++;
        if (n !== 0) begin bad++; $display("FAIL lat4_rst_drop got=%0d handshake cycles required=0", n); end
        txn(1, 1'b0, 32'h40, 4'hF, 32'h0, ra, va, rn, tl, rd, er);
        total++;
        if (rd !== 32'hCAFEF00D) begin bad++; $display("FAIL lat4_rst_nocommit got=%h required=cafef00d", rd); end
    endtask

    task automatic test_random();
        int ra, va, rn, tl, d;
        logic [31:0] rd, a, wd, ex;
        logic [3:0] s;
        logic er;
        bit wr;
        logic [3:0] strbs [4] = '{4'h0, 4'h1, 4'h3, 4'hF};
        for (int dd = 0; dd < 2; dd++) begin
            for (int i = 0; i < 16; i++) begin
                wd = $urandom;
                txn(dd, 1'b1, 32'h800 + 32'(4*i), 4'hF, wd, ra, va, rn, tl, rd, er);
                model_write(dd, 32'h800 + 32'(4*i), 4'hF, wd);
            end
        end
        for (int i = 0; i < 80; i++) begin
            d  = int'($urandom_range(0, 1));
            wr = 1'($urandom_range(0, 1));
            a  = 32'h800 + 32'($urandom_range(0, 63));
            s  = strbs[$urandom_range(0, 3)];
            wd = $urandom;
            ex = model_read(d, a, s);
            txn(d, wr, a, s, wd, ra, va, rn, tl, rd, er);
            total++;
            if (ra !== 1 || va !== (d == 1 ? 5 : 2) || rn !== 1 || tl !== 0) begin
                bad++; $display("FAIL rnd_timing op%0d got=%0d/%0d/%0d/%0d", i, ra, va, rn, tl);
            end
            if (wr) begin
                model_write(d, a, s, wd);
            end else begin
                total++;
                if (rd !== ex || er !== 1'b0) begin
                    bad++; $display("FAIL rnd_rd op%0d addr=%h strb=%h got=%h required=%h", i, a, s, rd, ex);
                end
            end
        end
    endtask

    task automatic test_oob();
        int ra, va, rn, tl;
        logic [31:0] rd;
        logic er;
        logic [31:0] exp0;
        exp0 = ERR_EN ? 32'h01020304 : 32'h77665544;
        txn(0, 1'b1, 32'h0, 4'hF, 32'h01020304, ra, va, rn, tl, rd, er);
        model_write(0, 32'h0, 4'hF, 32'h01020304);
        txn(0, 1'b1, 32'h1000, 4'hF, 32'h77665544, ra, va, rn, tl, rd, er);
        model_write(0, 32'h1000, 4'hF, 32'h77665544);
        total++;
        if (er !== ERR_EN || va !== 2) begin bad++; $display("FAIL oob_wr_err got=%b@%0d required=%b@2", er, va, ERR_EN); end
        txn(0, 1'b0, 32'h0, 4'hF, 32'h0, ra, va, rn, tl, rd, er);
        total++;
        if (rd !== exp0 || er !== 1'b0) begin bad++; $display("FAIL oob_word0 got=%h required=%h", rd, exp0); end
        txn(0, 1'b0, 32'h1000, 4'hF, 32'h0, ra, va, rn, tl, rd, er);
        total++;
        if (rd !== (ERR_EN ? 32'h0 : 32'h77665544) || er !== ERR_EN) begin
            bad++; $display("FAIL oob_rd got=%h err=%b", rd, er);
        end
    endtask

    initial begin
        rstn = 1'b0;
        r1_req = 1'b0; r1_addr = 32'h0; r1_strb = 4'h0;
        w1_req = 1'b0; w1_addr = 32'h0; w1_strb = 4'h0; w1_data = 32'h0;
        r4_req = 1'b0; r4_addr = 32'h0; r4_strb = 4'h0;
        w4_req = 1'b0; w4_addr = 32'h0; w4_strb = 4'h0; w4_data = 32'h0;
        test_reset();
        test_word();
        test_subword();
        test_collision();
        test_latency4();
        test_random();
        test_oob();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
